// File: rtl/pll_lock_reset_sequencer.sv
// PLL reset sequencer and lock supervisor, clocked from the PLL reference clock.
// Pulses the PLL reset, qualifies lock, and holds system reset until lock has been stable.
module pll_lock_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_rst,
  output logic             reset_out,
  output logic             ready,
  output logic             fail,
  output logic [CNT_W-1:0] lock_loss_count
);

  localparam int CYC_MAX_A = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int CYC_MAX   = (LOCK_TIMEOUT > CYC_MAX_A) ? LOCK_TIMEOUT : CYC_MAX_A;
  localparam int CW        = $clog2(CYC_MAX + 1);
  localparam int RW        = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0]    PLL_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] LOSS_SAT     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             cnt_hold;
  logic             pll_rst_q, reset_out_q, ready_q, fail_q;

  // Two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  assign locked_s = sync_q[1];

  // Next-state, shared cycle counter, retry and lock-loss bookkeeping
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    cnt_hold = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
        else                   state_d = RESET_PLL;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RW'(1);
          if ((retry_q + RW'(1)) == RETRY_LIMIT) state_d = FAILED;
          else                                   state_d = RESET_PLL;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          state_d = STABLE;
        end
      end
      RUN: begin
        cnt_hold = 1'b1;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (loss_q != LOSS_SAT) loss_d = loss_q + CNT_W'(1);
          else                    loss_d = loss_q;
        end else begin
          state_d = RUN;
        end
      end
      FAILED: begin
        cnt_hold = 1'b1;
        state_d  = FAILED;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    // Every state change restarts the shared counter
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_hold)      cnt_d = cnt_q;
    else                    cnt_d = cnt_q + CW'(1);
  end

  // State, counters, and outputs decoded from the next state so they are flop outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      reset_out_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == RESET_PLL);
      reset_out_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fail_q      <= (state_d == FAILED);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign reset_out       = reset_out_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: directed scenarios plus randomized lock patterns
// checked every cycle against a phase/duration reference model.
module tb_pll_lock_reset_sequencer;

  localparam int P_RST   = 4;
  localparam int T_OUT   = 20;
  localparam int Q_LEN   = 8;
  localparam int MAX_TRY = 3;
  localparam int CW      = 2;
  localparam int SAT     = (1 << CW) - 1;
  localparam int T_READY = P_RST + 1 + Q_LEN;

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_QUAL  = 2;
  localparam int PH_UP    = 3;
  localparam int PH_DEAD  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst, reset_out, ready, fail;
  logic [CW-1:0] lock_loss_count;

  int total = 0;
  int bad   = 0;

  int ph, spent, tries, losses;
  bit lhist[$];

  pll_lock_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (T_OUT),
    .STABLE_CYCLES (Q_LEN),
    .MAX_RETRIES   (MAX_TRY),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .locked         (locked),
    .pll_rst        (pll_rst),
    .reset_out      (reset_out),
    .ready          (ready),
    .fail           (fail),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph     = PH_PULSE;
    spent  = 0;
    tries  = 0;
    losses = 0;
    lhist  = {1'b0, 1'b0};
  endtask

  task automatic enter(input int p);
    ph    = p;
    spent = 0;
  endtask

  // One clock edge: the controller sees the lock value sampled two edges earlier
  task automatic model_edge(input bit lk);
    bit ls;
    ls = lhist[1];
    lhist.push_front(lk);
    void'(lhist.pop_back());
    spent++;
    case (ph)
      PH_PULSE: if (spent == P_RST) enter(PH_WAIT);
      PH_WAIT: begin
        if (ls) enter(PH_QUAL);
        else if (spent == T_OUT) begin
          tries++;
          enter((tries == MAX_TRY) ? PH_DEAD : PH_PULSE);
        end
      end
      PH_QUAL: begin
        if (!ls) enter(PH_WAIT);
        else if (spent == Q_LEN) begin
          tries = 0;
          enter(PH_UP);
        end
      end
      PH_UP: begin
        if (!ls) begin
          if (losses < SAT) losses++;
          enter(PH_WAIT);
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] model_vec();
    logic [5:0] v;
    v[5]   = (ph == PH_PULSE);
    v[4]   = (ph != PH_UP);
    v[3]   = (ph == PH_UP);
    v[2]   = (ph == PH_DEAD);
    v[1:0] = 2'(losses);
    return v;
  endfunction

  function automatic logic [5:0] dut_vec();
    return {pll_rst, reset_out, ready, fail, lock_loss_count};
  endfunction

  // Called at a falling edge: compare, drive the next lock value, advance one cycle
  task automatic step(input bit lk, input string tag);
    check(tag, 32'(dut_vec()), 32'(model_vec()));
    locked = lk;
    @(posedge clk);
    model_edge(lk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input bit lk);
    @(negedge clk);
    rst    = 1'b1;
    locked = lk;
    @(negedge clk);
    @(negedge clk);
    check("reset_vals", 32'(dut_vec()), 32'(6'b110000));
    rst = 1'b0;
    model_reset();
  endtask

  // Assert reset between edges and check outputs before any clock edge arrives
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(dut_vec()), 32'(6'b110000));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    bit lv;
    int len;
    model_reset();

    apply_reset(1'b1);
    for (int c = 0; c < 20; c++) begin
      check("clean_pll_rst", 32'(pll_rst), 32'(c < P_RST));
      check("clean_ready", 32'(ready), 32'(c >= T_READY));
      check("clean_fail", 32'(fail), 32'(0));
      step(1'b1, "clean_model");
    end
    for (int c = 20; c < 45; c++) begin
      check("loss_reset_out", 32'(reset_out), 32'(c >= 23 && c < 36));
      check("loss_count", 32'(lock_loss_count), 32'((c >= 23) ? 1 : 0));
      step((c < 20 || c >= 25), "loss_model");
    end

    apply_reset(1'b0);
    for (int c = 0; c < 100; c++) begin
      check("nolock_pll_rst", 32'(pll_rst), 32'(c < 72 && (c % 24) < P_RST));
      check("nolock_fail", 32'(fail), 32'(c >= 72));
      check("nolock_reset_out", 32'(reset_out), 32'(1));
      step(1'b0, "nolock_model");
    end

    apply_reset(1'b1);
    for (int c = 0; c < 25; c++) begin
      check("glitch_pll_rst", 32'(pll_rst), 32'(c < P_RST));
      check("glitch_ready", 32'(ready), 32'(c >= 19));
      step(!(c == 6 || c == 7), "glitch_model");
    end

    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 4; j++) step(1'b0, "sat_model");
      n = 0;
      while (!ready && n < 40) begin
        step(1'b1, "sat_model");
        n++;
      end
      check("sat_ready", 32'(ready), 32'(1));
      check("sat_count", 32'(lock_loss_count), 32'((k < SAT) ? k : SAT));
    end

    for (int j = 0; j < 2; j++) step(1'b0, "mid_model");
    for (int j = 0; j < 8; j++) step(1'b1, "mid_model");
    check("mid_pre_count", 32'(lock_loss_count), 32'(SAT));
    check("mid_pre_ready", 32'(ready), 32'(0));
    async_reset();
    for (int c = 0; c < 16; c++) begin
      check("mid_restart_ready", 32'(ready), 32'(c >= T_READY));
      step(1'b1, "mid_model");
    end

    for (int it = 0; it < 150; it++) begin
      lv  = ($urandom_range(0, 3) != 0);
      len = lv ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 24));
      if ($urandom_range(0, 19) == 0) async_reset();
      for (int j = 0; j < len; j++) step(lv, "rand_model");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
